// File: rtl/alu_op_sequencer.sv
// Multi-cycle control stage around the 32-bit datapath ALU: latches operands and
// opcode, holds the op for its latency, captures the 64-bit result into Z.
module alu_op_sequencer #(
    parameter int unsigned MUL_CYCLES = 16,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned ALU_CYCLES = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] alu_y,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [63:0] alu_c,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned RES_W   = 64;
    localparam int unsigned MAX_MD  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned MAX_LAT = (MAX_MD > ALU_CYCLES) ? MAX_MD : ALU_CYCLES;
    localparam int unsigned CNT_W   = int'($clog2(MAX_LAT)) + 1;

    localparam logic [OP_W-1:0] OP_MUL = 4'b0110;
    localparam logic [OP_W-1:0] OP_DIV = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_Y,
        EXEC,
        CAPTURE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   lat_m1;
    logic [DATA_W-1:0]  y_next;
    logic [DATA_W-1:0]  b_next;
    logic [OP_W-1:0]    op_next;
    logic [RES_W-1:0]   z;
    logic [RES_W-1:0]   z_next;
    logic               done_next;
    logic               err_next;
    logic               illegal_c;

    assign z_hi      = z[RES_W-1:DATA_W];
    assign z_lo      = z[DATA_W-1:0];
    assign illegal_c = (opcode[3:1] == 3'b111);

    // Execute-counter preload from the latched opcode
    always_comb begin
        lat_m1 = CNT_W'(ALU_CYCLES - 1);
        case (alu_op)
            OP_MUL:  lat_m1 = CNT_W'(MUL_CYCLES - 1);
            OP_DIV:  lat_m1 = CNT_W'(DIV_CYCLES - 1);
            default: lat_m1 = CNT_W'(ALU_CYCLES - 1);
        endcase
    end

    // State register plus all registered datapath/handshake outputs
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            cnt    <= '0;
            alu_y  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            z      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            alu_y  <= y_next;
            alu_b  <= b_next;
            alu_op <= op_next;
            z      <= z_next;
            busy   <= (state_next != IDLE);
            done   <= done_next;
            err    <= err_next;
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        y_next     = alu_y;
        b_next     = alu_b;
        op_next    = alu_op;
        z_next     = z;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (illegal_c) begin
                        err_next = 1'b1;
                    end else begin
                        op_next    = opcode;
                        b_next     = operand_b;
                        state_next = LOAD_Y;
                    end
                end
            end
            LOAD_Y: begin
                y_next     = operand_a;
                cnt_next   = lat_m1;
                state_next = EXEC;
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_next = CAPTURE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            CAPTURE: begin
                z_next     = alu_c;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios then randomized
// transactions against a transaction-level timing/result model.
module tb_alu_op_sequencer;

    logic        clock;
    logic        clear;
    logic        start;
    logic [3:0]  opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] alu_y;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [63:0] alu_c;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        busy;
    logic        done;
    logic        err;

    int          n_checks;
    int          n_errors;
    logic [63:0] model_z;

    alu_op_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .opcode    (opcode),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .alu_y     (alu_y),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .z_hi      (z_hi),
        .z_lo      (z_lo),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'b0110: return 16;
            4'b0111: return 32;
            default: return 1;
        endcase
    endfunction

    // One legal op; entered and left on a falling edge with the block idle.
    // junk_k: cycle at which a stray start is driven while busy (-1 = none).
    // abort_k: cycle at which reset is asserted mid-op (-1 = none).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] c, input int junk_k, input logic [3:0] junk_op,
                          input int abort_k);
        int lat;
        lat       = lat_of(op);
        start     = 1'b1;
        opcode    = op;
        operand_b = b;
        operand_a = $urandom;
        alu_c     = {$urandom, $urandom};
        for (int k = 0; k <= lat + 2; k++) begin
            @(negedge clock);
            check("busy", 64'(busy), 64'(k <= lat + 1));
            check("done", 64'(done), 64'(k == lat + 2));
            check("err_busy", 64'(err), 64'd0);
            check("alu_b", 64'(alu_b), 64'(b));
            check("alu_op", 64'(alu_op), 64'(op));
            if (k >= 1) check("alu_y", 64'(alu_y), 64'(a));
            if (k == lat + 2) begin
                model_z = c;
                check("z", {z_hi, z_lo}, model_z);
            end else begin
                check("z_hold", {z_hi, z_lo}, model_z);
            end
            if (k == abort_k) begin
                clear = 1'b0;
                start = 1'b0;
                #1;
                model_z = 64'd0;
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                check("rst_z", {z_hi, z_lo}, model_z);
                check("rst_y", 64'(alu_y), 64'd0);
                check("rst_op", 64'(alu_op), 64'd0);
                return;
            end
            start     = (k == junk_k) && (k >= 1) && (k <= lat + 1);
            opcode    = (k == junk_k) ? junk_op : 4'($urandom);
            operand_a = (k == 0) ? a : $urandom;
            operand_b = $urandom;
            alu_c     = (k == lat + 1) ? c : {$urandom, $urandom};
        end
        start = 1'b0;
    endtask

    task automatic run_illegal(input logic [3:0] op);
        start  = 1'b1;
        opcode = op;
        @(negedge clock);
        check("err_pulse", 64'(err), 64'd1);
        check("err_no_busy", 64'(busy), 64'd0);
        check("err_no_done", 64'(done), 64'd0);
        check("err_z", {z_hi, z_lo}, model_z);
        start = 1'b0;
        @(negedge clock);
        check("err_one_cycle", 64'(err), 64'd0);
        check("err_idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_done", 64'(done), 64'd0);
            check("idle_err", 64'(err), 64'd0);
            check("idle_z", {z_hi, z_lo}, model_z);
        end
    endtask

    initial begin
        logic [3:0] rop;
        n_checks  = 0;
        n_errors  = 0;
        model_z   = 64'd0;
        clear     = 1'b0;
        start     = 1'b0;
        opcode    = 4'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        alu_c     = 64'd0;
        repeat (2) @(negedge clock);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_z", {z_hi, z_lo}, 64'd0);
        check("reset_y", 64'(alu_y), 64'd0);
        check("reset_b", 64'(alu_b), 64'd0);
        clear = 1'b1;
        idle_cycles(2);

        // ADD 5+7 -> 12, then DIV reset mid-EXEC clears Z with no done
        run_op(4'b0011, 32'd5, 32'd7, 64'd12, -1, 4'd0, -1);
        idle_cycles(1);
        run_op(4'b0111, 32'd100, 32'd3, 64'h55, -1, 4'd0, 11);
        @(negedge clock);
        clear = 1'b1;
        idle_cycles(4);

        run_op(4'b0110, 32'h10000, 32'h10000, 64'h1_0000_0000, -1, 4'd0, -1);
        check("mul_z_hi", 64'(z_hi), 64'd1);
        check("mul_z_lo", 64'(z_lo), 64'd0);
        idle_cycles(1);

        // DIV with stray start at EXEC cycle 5 -> ignored
        run_op(4'b0111, 32'd1000, 32'd7, 64'd142, 5, 4'b0000, -1);
        idle_cycles(2);

        // ADD then SUB back-to-back, no bubble
        run_op(4'b0011, 32'd9, 32'd4, 64'd13, -1, 4'd0, -1);
        run_op(4'b0100, 32'd9, 32'd4, 64'd5, -1, 4'd0, -1);
        run_illegal(4'b1111);
        run_illegal(4'b1110);
        idle_cycles(1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                run_illegal(4'($urandom_range(14, 15)));
            end else begin
                rop = 4'($urandom_range(0, 13));
                run_op(rop, $urandom, $urandom, {$urandom, $urandom},
                       ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2)) : -1,
                       4'($urandom), -1);
            end
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
